// File: rtl/f779_pkg.sv
// Shared definitions for the 74F779 command sequencer.
// Command opcodes, {S1,S0} mode encodings and the controller state enum.
// No logic; imported by f779_sequencer.
package f779_pkg;

  // Command opcodes carried on cmd_op
  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_UP   = 2'd1;
  localparam logic [1:0] OP_DOWN = 2'd2;
  localparam logic [1:0] OP_READ = 2'd3;

  // Counter mode select, packed as {S1,S0}
  localparam logic [1:0] MODE_LOAD = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_COUNT = 3'd2,
    ST_RDON  = 3'd3,
    ST_RDCAP = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

endpackage

// File: rtl/f779_sequencer.sv
// Command-driven controller for one 74F779 up/down counter on a shared 3-state bus.
// Latency: LOAD 2, UP/DOWN N+1 (1 for N=0), READ 3 cycles from accept to rsp_valid.
// Backpressure: one command in flight; cmd_ready stays low until the response is taken.
//
// Ports:
//   CP, mr_n                   clock (shared with the counter) and async active-low reset
//   cmd_valid/ready/op/data    command port; data is the LOAD value or step count N
//   rsp_valid/ready/data/tc    response port; held stable until taken
//   S0, S1, cet_n, oe_n        counter control pins
//   bus_out, bus_oe, bus_in    controller half of the bidirectional InotO bus
//   tc_n                       counter terminal-count, active-low
module f779_sequencer
  import f779_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NW    = 8
) (
  input  logic             CP,
  input  logic             mr_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_tc,
  output logic             S0,
  output logic             S1,
  output logic             cet_n,
  output logic             oe_n,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             tc_n
);

  state_e           state_q, state_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic             dir_up_q, dir_up_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_tc_q, rsp_tc_d;

  // Registered pin/port outputs, decoded from the next state
  logic [1:0]       mode_q, mode_d;
  logic             cet_n_q, cet_n_d;
  logic             oe_n_q, oe_n_d;
  logic             bus_oe_q, bus_oe_d;
  logic [WIDTH-1:0] bus_out_q, bus_out_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_up_d   = dir_up_q;
    rsp_data_d = rsp_data_q;
    rsp_tc_d   = rsp_tc_q;
    bus_out_d  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          rsp_tc_d = 1'b0;
          unique case (cmd_op)
            OP_LOAD: begin
              state_d    = ST_LOAD;
              rsp_data_d = cmd_data;
              bus_out_d  = cmd_data;
            end
            OP_UP, OP_DOWN: begin
              dir_up_d   = (cmd_op == OP_UP);
              cnt_d      = cmd_data[NW-1:0];
              // Steps performed equals N, known at accept time
              rsp_data_d = WIDTH'(cmd_data[NW-1:0]);
              state_d    = (cmd_data[NW-1:0] == '0) ? ST_RESP : ST_COUNT;
            end
            default: begin
              state_d = ST_RDON;
            end
          endcase
        end
      end
      ST_LOAD: begin
        state_d = ST_RESP;
      end
      ST_COUNT: begin
        // tc_n reflects the value the counter holds during this enabled cycle
        if (!tc_n) rsp_tc_d = 1'b1;
        if (cnt_q == NW'(1)) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - NW'(1);
        end
      end
      ST_RDON: begin
        state_d = ST_RDCAP;
      end
      ST_RDCAP: begin
        rsp_data_d = bus_in;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Moore decode of the state being entered; registered below so every
    // output is a flop and nothing on the counter side sees cmd_* directly.
    mode_d      = MODE_HOLD;
    cet_n_d     = 1'b1;
    oe_n_d      = 1'b1;
    bus_oe_d    = 1'b0;
    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    unique case (state_d)
      ST_IDLE:  cmd_ready_d = 1'b1;
      ST_LOAD: begin
        // LOAD is only entered from IDLE, where oe_n was already high,
        // so the counter's drivers are off for a full cycle before ours turn on.
        mode_d   = MODE_LOAD;
        bus_oe_d = 1'b1;
      end
      ST_COUNT: begin
        mode_d  = dir_up_d ? MODE_UP : MODE_DOWN;
        cet_n_d = 1'b0;
      end
      ST_RDON, ST_RDCAP: oe_n_d = 1'b0;
      ST_RESP:  rsp_valid_d = 1'b1;
      default:  cmd_ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge CP or negedge mr_n) begin
    if (!mr_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dir_up_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tc_q    <= 1'b0;
      mode_q      <= MODE_HOLD;
      cet_n_q     <= 1'b1;
      oe_n_q      <= 1'b1;
      bus_oe_q    <= 1'b0;
      bus_out_q   <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_up_q    <= dir_up_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tc_q    <= rsp_tc_d;
      mode_q      <= mode_d;
      cet_n_q     <= cet_n_d;
      oe_n_q      <= oe_n_d;
      bus_oe_q    <= bus_oe_d;
      bus_out_q   <= bus_out_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tc    = rsp_tc_q;
  assign S1        = mode_q[1];
  assign S0        = mode_q[0];
  assign cet_n     = cet_n_q;
  assign oe_n      = oe_n_q;
  assign bus_oe    = bus_oe_q;
  assign bus_out   = bus_out_q;

endmodule

// File: tb/tb_f779_sequencer.sv
// Bench for f779_sequencer with a behavioural 74F779 counter on the bus.
// Expected responses are queued by the stimulus and checked by a monitor.
// Latency, enable-pulse counts, stall hold and mid-run reset are checked inline.
module tb_f779_sequencer;
  import f779_pkg::*;

  logic       CP;
  logic       mr_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_tc;
  logic       S0, S1, cet_n, oe_n;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] bus_in;
  logic       tc_n;

  logic [7:0] dev_q;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cet_low  = 0;
  logic       prev_oe_n = 1'b1;

  typedef struct packed {
    logic       tc;
    logic [7:0] d;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  f779_sequencer #(.WIDTH(8), .NW(8)) dut (
    .CP(CP), .mr_n(mr_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tc(rsp_tc),
    .S0(S0), .S1(S1), .cet_n(cet_n), .oe_n(oe_n),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in), .tc_n(tc_n)
  );

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  // Behavioural 74F779: acts on the CP edge, no reset of its contents
  initial dev_q = 8'h00;
  always @(posedge CP) begin
    case ({S1, S0})
      2'b00:   dev_q <= bus_oe ? bus_out : 8'hFF;
      2'b10:   if (!cet_n) dev_q <= dev_q + 8'h01;
      2'b01:   if (!cet_n) dev_q <= dev_q - 8'h01;
      default: dev_q <= dev_q;
    endcase
  end
  assign tc_n   = !(!cet_n && ((({S1, S0} == 2'b10) && (dev_q == 8'hFF)) ||
                               (({S1, S0} == 2'b01) && (dev_q == 8'h00))));
  // Pull-up when nobody drives the bus
  assign bus_in = !oe_n ? dev_q : (bus_oe ? bus_out : 8'hFF);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop on handshake, bus turnaround invariant
  always @(negedge CP) begin
    if (mr_n) begin
      if (!cet_n) cet_low++;
      if (bus_oe) begin
        check("bus_oe_with_oe_n", {31'b0, oe_n}, 32'd1);
        check("bus_oe_after_oe_n", {31'b0, prev_oe_n}, 32'd1);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_data", {24'b0, rsp_data}, {24'b0, mon_e.d});
          check("rsp_tc", {31'b0, rsp_tc}, {31'b0, mon_e.tc});
        end
      end
    end
    prev_oe_n = oe_n;
  end

  task automatic wait_accept();
    int n;
    n = 0;
    do begin
      @(negedge CP);
      n++;
    end while (!cmd_ready && n < 50);
    check("accept", {31'b0, cmd_ready}, 32'd1);
    @(posedge CP);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input logic [7:0] ed,
                        input logic etc, input int elat, input int ecet, input bit stall);
    int n;
    int c0;
    logic [7:0] hd;
    exp_q.push_back({etc, ed});
    if (stall) rsp_ready = 1'b0;
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    wait_accept();
    c0 = cet_low;
    n = 0;
    do begin
      @(negedge CP);
      n++;
    end while (!rsp_valid && n < 100);
    check("latency", n, elat);
    check("cet_low_cycles", cet_low - c0, ecet);
    if (stall) begin
      hd = rsp_data;
      for (int i = 0; i < 5; i++) begin
        @(negedge CP);
        check("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("stall_rsp_data", {24'b0, rsp_data}, {24'b0, hd});
        check("stall_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("stall_mode", {30'b0, S1, S0}, 32'd3);
        check("stall_cet_n", {31'b0, cet_n}, 32'd1);
      end
      @(posedge CP);
      #1;
      rsp_ready = 1'b1;
    end
    n = 0;
    do begin
      @(posedge CP);
      #1;
      n++;
    end while (rsp_valid && n < 10);
    check("rsp_taken", {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_rsp_data"}, {24'b0, rsp_data}, 32'd0);
    check({tag, "_rsp_tc"}, {31'b0, rsp_tc}, 32'd0);
    check({tag, "_mode"}, {30'b0, S1, S0}, 32'd3);
    check({tag, "_cet_n"}, {31'b0, cet_n}, 32'd1);
    check({tag, "_oe_n"}, {31'b0, oe_n}, 32'd1);
    check({tag, "_bus_oe"}, {31'b0, bus_oe}, 32'd0);
    check({tag, "_bus_out"}, {24'b0, bus_out}, 32'd0);
  endtask

  initial begin
    mr_n      = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_LOAD;
    cmd_data  = 8'h00;
    rsp_ready = 1'b1;
    #2;
    mr_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge CP);
    #1;
    mr_n = 1'b1;
    @(posedge CP);
    #1;

    //     op       data   exp   tc    lat cet stall
    do_cmd(OP_LOAD, 8'hA5, 8'hA5, 1'b0, 2, 0, 1'b0);
    do_cmd(OP_READ, 8'h00, 8'hA5, 1'b0, 3, 0, 1'b0);
    do_cmd(OP_LOAD, 8'hFE, 8'hFE, 1'b0, 2, 0, 1'b0);
    do_cmd(OP_UP,   8'd3,  8'd3,  1'b1, 4, 3, 1'b0);
    do_cmd(OP_READ, 8'h00, 8'h01, 1'b0, 3, 0, 1'b0);
    do_cmd(OP_LOAD, 8'h02, 8'h02, 1'b0, 2, 0, 1'b0);
    do_cmd(OP_DOWN, 8'd2,  8'd2,  1'b0, 3, 2, 1'b0);
    do_cmd(OP_READ, 8'h00, 8'h00, 1'b0, 3, 0, 1'b0);
    do_cmd(OP_DOWN, 8'd1,  8'd1,  1'b1, 2, 1, 1'b0);
    do_cmd(OP_READ, 8'h00, 8'hFF, 1'b0, 3, 0, 1'b0);
    do_cmd(OP_DOWN, 8'd0,  8'd0,  1'b0, 1, 0, 1'b0);
    do_cmd(OP_READ, 8'h00, 8'hFF, 1'b0, 3, 0, 1'b0);
    // FF + 4 steps: terminal count seen on the first step, ends at 03
    do_cmd(OP_UP,   8'd4,  8'd4,  1'b1, 5, 4, 1'b1);
    do_cmd(OP_READ, 8'h00, 8'h03, 1'b0, 3, 0, 1'b0);

    // Reset during the second enabled cycle of UP N=10
    do_cmd(OP_LOAD, 8'h10, 8'h10, 1'b0, 2, 0, 1'b0);
    cmd_op    = OP_UP;
    cmd_data  = 8'd10;
    cmd_valid = 1'b1;
    wait_accept();
    @(posedge CP);
    #1;
    mr_n = 1'b0;
    #1;
    check_reset_outputs("midrun");
    @(posedge CP);
    #1;
    mr_n = 1'b1;
    @(posedge CP);
    #1;
    // One step taken at the first enabled edge only
    do_cmd(OP_READ, 8'h00, 8'h11, 1'b0, 3, 0, 1'b0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
